// File: rtl/program_loader.sv
// Writes a byte-streamed program image (LE word count N, then N LE words)
// into instruction memory as 32-bit words at byte addresses 0, 4, 8, ...
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 2 ** (ADDR_WIDTH - 2)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int          WCW   = ADDR_WIDTH - 2;
    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           len_q, len_d;
    logic [23:0]           word_q, word_d;
    logic [WCW-1:0]        word_cnt_q, word_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_address_q, wr_address_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic        accept;
    logic [31:0] len_full;
    logic        last_word;

    assign in_ready  = (state_q == LEN) || (state_q == DATA);
    assign accept    = in_valid && in_ready;
    assign len_full  = {in_data, len_q[23:0]};
    // N is known to be 1..MAX_WORDS in DATA, so N-1 always fits the word counter
    assign last_word = (32'(word_cnt_q) == (len_q - 32'd1));

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        len_d        = len_q;
        word_d       = word_q;
        word_cnt_d   = word_cnt_q;
        wr_en_d      = 1'b0;
        wr_address_d = wr_address_q;
        wr_data_d    = wr_data_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            LEN: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    len_d[7:0]   = in_data;
                        2'd1:    len_d[15:8]  = in_data;
                        2'd2:    len_d[23:16] = in_data;
                        default: begin
                            len_d = len_full;
                            if (len_full == 32'd0) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else if (len_full > MAX_N) begin
                                state_d = ERROR;
                                error_d = 1'b1;
                            end else begin
                                state_d = DATA;
                            end
                        end
                    endcase
                end
            end
            DATA: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    word_d[7:0]   = in_data;
                        2'd1:    word_d[15:8]  = in_data;
                        2'd2:    word_d[23:16] = in_data;
                        default: begin
                            wr_en_d      = 1'b1;
                            wr_data_d    = {in_data, word_q};
                            wr_address_d = {word_cnt_q, 2'b00};
                            word_cnt_d   = word_cnt_q + 1'b1;
                            if (last_word) begin
                                state_d = DONE;
                            end
                        end
                    endcase
                end
            end
            default: begin
                // done rises one cycle after the final write strobe
                if (state_q == DONE) begin
                    done_d = 1'b1;
                end
                if (start) begin
                    state_d    = LEN;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    len_d      = 32'd0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end
            end
        endcase

        busy_d = (state_d == LEN) || (state_d == DATA);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 2'd0;
            len_q        <= 32'd0;
            word_q       <= 24'd0;
            word_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_address_q <= '0;
            wr_data_q    <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            len_q        <= len_d;
            word_q       <= word_d;
            word_cnt_q   <= word_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_address_q <= wr_address_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_address = wr_address_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a small (16-word) memory.
module tb_program_loader;

    localparam int AW   = 6;
    localparam int MAXW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_address;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          error;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_drops = 0;

    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];
    int            wc[$];

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(wr_address);
            wd.push_back(wr_data);
            wc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1);
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    // All stimulus tasks are entered and left on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin
                @(negedge clk);
                if (!in_ready) ready_drops++;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_byte: in_ready stuck at %b, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], (gmax == 0) ? 0 : int'($urandom_range(0, gmax)));
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_vec++; if (wr_address !== '0) begin n_err++; $display("FAIL reset_wr_address: got %h want 0", wr_address); end
        n_vec++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        n_vec++; if ({busy, done, error} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, done, error}); end
    endtask

    task automatic test_single();
        clear_log();
        do_start();
        n_vec++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL single_busy: busy=%b in_ready=%b want 1 1", busy, in_ready); end
        send_word(32'd1, 0);
        send_word(32'h00000013, 0);
        go_idle();
        n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en: got %b want 1", wr_en); end
        n_vec++; if (wr_address !== '0) begin n_err++; $display("FAIL single_addr: got %h want 0", wr_address); end
        n_vec++; if (wr_data !== 32'h00000013) begin n_err++; $display("FAIL single_data: got %h want 00000013", wr_data); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_early: got %b want 0", done); end
        @(negedge clk);
        n_vec++; if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin n_err++; $display("FAIL single_done: done=%b busy=%b wr_en=%b want 1 0 0", done, busy, wr_en); end
        n_vec++; if (wa.size() != 1) begin n_err++; $display("FAIL single_count: got %0d writes want 1", wa.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w[3];
        exp_w[0] = 32'h11223344; exp_w[1] = 32'hAABBCCDD; exp_w[2] = 32'hDEADBEEF;
        clear_log();
        do_start();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_clear: got %b want 0", done); end
        send_word(32'd3, 0);
        for (int i = 0; i < 3; i++) send_word(exp_w[i], 0);
        go_idle();
        repeat (2) @(negedge clk);
        n_vec++; if (wa.size() != 3) begin n_err++; $display("FAIL b2b_count: got %0d writes want 3", wa.size()); end
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            n_vec++; if (wa[i] !== AW'(4*i) || wd[i] !== exp_w[i]) begin n_err++; $display("FAIL b2b_word%0d: got %h/%h want %h/%h", i, wa[i], wd[i], AW'(4*i), exp_w[i]); end
        end
        for (int i = 1; i < 3 && i < wc.size(); i++) begin
            n_vec++; if (wc[i] - wc[i-1] != 4) begin n_err++; $display("FAIL b2b_spacing%0d: got %0d cycles want 4", i, wc[i] - wc[i-1]); end
        end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", done); end
    endtask

    task automatic test_gaps();
        logic [31:0] exp_w[2];
        exp_w[0] = 32'h0BADF00D; exp_w[1] = 32'h87654321;
        clear_log();
        do_start();
        send_word(32'd2, 5);
        ready_drops = 0;
        for (int i = 0; i < 2; i++) send_word(exp_w[i], 5);
        go_idle();
        repeat (2) @(negedge clk);
        n_vec++; if (ready_drops != 0) begin n_err++; $display("FAIL gaps_ready: %0d gap cycles with in_ready low, want 0", ready_drops); end
        n_vec++; if (wa.size() != 2) begin n_err++; $display("FAIL gaps_count: got %0d writes want 2", wa.size()); end
        for (int i = 0; i < 2 && i < wa.size(); i++) begin
            n_vec++; if (wa[i] !== AW'(4*i) || wd[i] !== exp_w[i]) begin n_err++; $display("FAIL gaps_word%0d: got %h/%h want %h/%h", i, wa[i], wd[i], AW'(4*i), exp_w[i]); end
        end
    endtask

    task automatic test_zero_and_error();
        clear_log();
        do_start();
        send_word(32'd0, 0);
        go_idle();
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL zero_done: done=%b busy=%b want 1 0", done, busy); end
        repeat (3) @(negedge clk);
        n_vec++; if (wa.size() != 0) begin n_err++; $display("FAIL zero_writes: got %0d want 0", wa.size()); end

        do_start();
        send_word(32'(MAXW + 1), 0);
        go_idle();
        n_vec++; if (error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL err_flags: error=%b in_ready=%b busy=%b want 1 0 0", error, in_ready, busy); end
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (5) @(negedge clk);
        go_idle();
        n_vec++; if (wa.size() != 0 || error !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL err_hold: writes=%0d error=%b done=%b want 0 1 0", wa.size(), error, done); end
    endtask

    task automatic test_full();
        int bad;
        clear_log();
        do_start();
        n_vec++; if (error !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL full_err_clear: error=%b busy=%b want 0 1", error, busy); end
        send_word(32'(MAXW), 0);
        for (int i = 0; i < MAXW; i++) send_word(32'hA0000000 + 32'(i), 0);
        go_idle();
        repeat (3) @(negedge clk);
        n_vec++; if (wa.size() != MAXW) begin n_err++; $display("FAIL full_count: got %0d writes want %0d", wa.size(), MAXW); end
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] !== AW'(4*i) || wd[i] !== 32'hA0000000 + 32'(i)) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL full_words: %0d wrong writes, want 0", bad); end
        n_vec++; if (wa.size() > 0 && wa[wa.size()-1] !== AW'(2**AW - 4)) begin n_err++; $display("FAIL full_last_addr: got %h want %h", wa[wa.size()-1], AW'(2**AW - 4)); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL full_done: got %b want 1", done); end

        clear_log();
        do_start();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reload_done_fall: got %b want 0", done); end
        send_word(32'd1, 0);
        send_word(32'h5555AAAA, 0);
        go_idle();
        repeat (2) @(negedge clk);
        n_vec++; if (wa.size() != 1 || wa[0] !== '0 || wd[0] !== 32'h5555AAAA) begin n_err++; $display("FAIL reload_word: writes=%0d first=%h/%h want 1 00/5555aaaa", wa.size(), (wa.size() > 0) ? wa[0] : '0, (wd.size() > 0) ? wd[0] : 32'd0); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] exp_w[2];
        exp_w[0] = 32'hCAFEF00D; exp_w[1] = 32'h01234567;
        clear_log();
        do_start();
        send_word(32'd2, 0);
        send_byte(8'h99, 0);
        send_byte(8'h88, 0);
        go_idle();
        reset_n = 1'b0;
        #1;
        n_vec++; if ({in_ready, wr_en, busy, done, error} !== 5'b00000 || wr_address !== '0 || wr_data !== 32'd0) begin n_err++; $display("FAIL midreset_outputs: rdy/wr/busy/done/err=%b addr=%h data=%h want 00000 0 0", {in_ready, wr_en, busy, done, error}, wr_address, wr_data); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++; if (wa.size() != 0 || in_ready !== 1'b0) begin n_err++; $display("FAIL midreset_idle: writes=%0d in_ready=%b want 0 0", wa.size(), in_ready); end
        do_start();
        send_word(32'd2, 0);
        for (int i = 0; i < 2; i++) send_word(exp_w[i], 0);
        go_idle();
        repeat (2) @(negedge clk);
        n_vec++; if (wa.size() != 2) begin n_err++; $display("FAIL midreset_count: got %0d writes want 2", wa.size()); end
        for (int i = 0; i < 2 && i < wa.size(); i++) begin
            n_vec++; if (wa[i] !== AW'(4*i) || wd[i] !== exp_w[i]) begin n_err++; $display("FAIL midreset_word%0d: got %h/%h want %h/%h", i, wa[i], wd[i], AW'(4*i), exp_w[i]); end
        end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL midreset_done: got %b want 1", done); end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_single();
        test_back_to_back();
        test_gaps();
        test_zero_and_error();
        test_full();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
